// File: rtl/imem_loader.sv
// Serial instruction-RAM loader: takes a little-endian word count followed by
// little-endian 32-bit words, writes them to RAM and releases the CPU reset once done.
module imem_loader #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_e;

    // One spare bit so that counts up to 65535 compare against DEPTH cleanly.
    localparam logic [16:0] DEPTH_C = 17'(DEPTH);

    state_e              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         word_q, word_d;
    logic [1:0]          byte_q, byte_d;
    logic [23:0]         asm_q, asm_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;

    logic                xfer_s;
    logic [15:0]         len_full_s;
    logic [15:0]         word_inc_s;

    assign xfer_s     = in_valid & ready_q;
    assign len_full_s = {in_data, len_q[7:0]};
    assign word_inc_s = word_q + 16'd1;

    // Next-state, datapath and output decode for the load sequence.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_d      = word_q;
        byte_d      = byte_q;
        asm_d       = asm_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN0;
                    len_d   = 16'd0;
                    word_d  = 16'd0;
                    byte_d  = 2'd0;
                    asm_d   = 24'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN0: begin
                if (xfer_s) begin
                    len_d   = {8'd0, in_data};
                    state_d = S_LEN1;
                end else begin
                    state_d = S_LEN0;
                end
            end
            S_LEN1: begin
                if (xfer_s) begin
                    len_d  = len_full_s;
                    word_d = 16'd0;
                    byte_d = 2'd0;
                    if (len_full_s == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, len_full_s} > DEPTH_C) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN1;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    byte_d = byte_q + 2'd1;
                    // Bytes arrive LSB first; the 4th byte completes the word.
                    if (byte_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = word_q[ADDR_W-1:0];
                        wdata_d = {in_data, asm_q};
                        word_d  = word_inc_s;
                        if (word_inc_s == len_q) begin
                            state_d = S_FLUSH;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        asm_d = {in_data, asm_q[23:8]};
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d     = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
        busy_d      = ready_d || (state_d == S_FLUSH);
        done_d      = (state_d == S_DONE);
        err_d       = (state_d == S_ERROR);
        cpu_rst_n_d = (state_d == S_DONE);
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= 16'd0;
            word_q      <= 16'd0;
            byte_q      <= 2'd0;
            asm_q       <= 24'd0;
            we_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= 32'd0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_q      <= word_d;
            byte_q      <= byte_d;
            asm_q       <= asm_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign in_ready  = ready_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a RAM model and write log capture mem_we traffic,
// each scenario task checks outputs against hand-computed values.
module tb_imem_loader;
    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int failures = 0;

    logic [31:0]       ram [0:DEPTH-1];
    logic [ADDR_W-1:0] log_addr [0:8191];
    logic [31:0]       log_data [0:8191];
    int                wr_count = 0;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // RAM model and write log fed by the DUT write port.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            ram[mem_addr] <= mem_wdata;
            if (wr_count < 8192) begin
                log_addr[wr_count] <= mem_addr;
                log_data[wr_count] <= mem_wdata;
            end
            wr_count <= wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  wait_n;
        logic took;
        wait_n = 0;
        took = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data = b;
        while (!took && wait_n < 20) begin
            took = in_ready;
            tick();
            wait_n++;
        end
        in_valid = 1'b0;
        if (!took) begin
            failures++;
            $display("FAIL send_byte_timeout byte=%02h in_ready=%0b required=1", b, in_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
        checks++; if (mem_addr !== 12'd0) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL rst_mem_wdata got=%08h exp=0", mem_wdata); end
        checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL rst_cpu_rst_n got=%0b exp=0", cpu_rst_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready got=%0b exp=0", in_ready); end
    endtask

    task automatic test_basic();
        int c0;
        c0 = wr_count;
        pulse_start();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_len0 in_ready=%0b busy=%0b exp=1,1", in_ready, busy); end
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h00500513);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 12'd0 || mem_wdata !== 32'h00500513) begin
            failures++; $display("FAIL basic_w0 we=%0b addr=%0h data=%08h exp=1,0,00500513", mem_we, mem_addr, mem_wdata); end
        send_word(32'h00001073);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 12'd1 || mem_wdata !== 32'h00001073) begin
            failures++; $display("FAIL basic_w1 we=%0b addr=%0h data=%08h exp=1,1,00001073", mem_we, mem_addr, mem_wdata); end
        checks++; if (busy !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL basic_flush busy=%0b done=%0b cpu_rst_n=%0b in_ready=%0b exp=1,0,0,0", busy, done, cpu_rst_n, in_ready); end
        tick();
        checks++; if (done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL basic_done done=%0b cpu_rst_n=%0b busy=%0b we=%0b exp=1,1,0,0", done, cpu_rst_n, busy, mem_we); end
        checks++; if (wr_count - c0 !== 2) begin failures++; $display("FAIL basic_wr_count got=%0d exp=2", wr_count - c0); end
    endtask

    task automatic test_stall();
        int c0;
        logic [7:0] img [0:9];
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h73, 8'h10, 8'h00, 8'h00};
        c0 = wr_count;
        pulse_start();
        checks++; if (cpu_rst_n !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL stall_restart cpu_rst_n=%0b done=%0b exp=0,0", cpu_rst_n, done); end
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                pulse_start();
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_start_ignored busy=%0b exp=1", busy); end
            end
            send_byte(img[i], int'($urandom_range(0, 3)));
        end
        tick();
        checks++; if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin failures++; $display("FAIL stall_done done=%0b cpu_rst_n=%0b exp=1,1", done, cpu_rst_n); end
        checks++; if (wr_count - c0 !== 2) begin failures++; $display("FAIL stall_wr_count got=%0d exp=2", wr_count - c0); end
        checks++; if (log_addr[c0] !== 12'd0 || log_data[c0] !== 32'h00500513) begin
            failures++; $display("FAIL stall_w0 addr=%0h data=%08h exp=0,00500513", log_addr[c0], log_data[c0]); end
        checks++; if (log_addr[c0+1] !== 12'd1 || log_data[c0+1] !== 32'h00001073) begin
            failures++; $display("FAIL stall_w1 addr=%0h data=%08h exp=1,00001073", log_addr[c0+1], log_data[c0+1]); end
    endtask

    task automatic test_zero_len();
        int c0;
        c0 = wr_count;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++; if (done !== 1'b1 || cpu_rst_n !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL zero_done done=%0b cpu_rst_n=%0b busy=%0b in_ready=%0b exp=1,1,0,0", done, cpu_rst_n, busy, in_ready); end
        tick();
        checks++; if (wr_count - c0 !== 0) begin failures++; $display("FAIL zero_wr_count got=%0d exp=0", wr_count - c0); end
    endtask

    task automatic test_too_long();
        int c0;
        c0 = wr_count;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        checks++; if (err !== 1'b1 || cpu_rst_n !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL long_err err=%0b cpu_rst_n=%0b in_ready=%0b done=%0b busy=%0b exp=1,0,0,0,0", err, cpu_rst_n, in_ready, done, busy); end
        in_valid = 1'b1;
        in_data = 8'hAA;
        repeat (3) tick();
        in_valid = 1'b0;
        checks++; if (wr_count - c0 !== 0 || err !== 1'b1) begin failures++; $display("FAIL long_no_write writes=%0d err=%0b exp=0,1", wr_count - c0, err); end
        pulse_start();
        checks++; if (err !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++; $display("FAIL long_restart err=%0b busy=%0b in_ready=%0b exp=0,1,1", err, busy, in_ready); end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL long_recover done=%0b exp=1", done); end
    endtask

    task automatic test_full();
        int c0;
        c0 = wr_count;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        for (int k = 0; k < DEPTH; k++) send_word(32'hC0DE0000 + 32'(k));
        checks++; if (mem_we !== 1'b1 || mem_addr !== 12'hFFF || mem_wdata !== 32'hC0DE0FFF) begin
            failures++; $display("FAIL full_last we=%0b addr=%0h data=%08h exp=1,fff,c0de0fff", mem_we, mem_addr, mem_wdata); end
        tick();
        checks++; if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin failures++; $display("FAIL full_done done=%0b cpu_rst_n=%0b exp=1,1", done, cpu_rst_n); end
        checks++; if (wr_count - c0 !== DEPTH) begin failures++; $display("FAIL full_wr_count got=%0d exp=%0d", wr_count - c0, DEPTH); end
        checks++; if (ram[0] !== 32'hC0DE0000 || ram[2048] !== 32'hC0DE0800 || ram[4095] !== 32'hC0DE0FFF) begin
            failures++; $display("FAIL full_ram r0=%08h r2048=%08h r4095=%08h exp=c0de0000,c0de0800,c0de0fff", ram[0], ram[2048], ram[4095]); end
        pulse_start();
        checks++; if (cpu_rst_n !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL full_rerun cpu_rst_n=%0b done=%0b exp=0,0", cpu_rst_n, done); end
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hFEEDF00D);
        checks++; if (cpu_rst_n !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 12'd0) begin
            failures++; $display("FAIL full_rerun_flush cpu_rst_n=%0b we=%0b addr=%0h exp=0,1,0", cpu_rst_n, mem_we, mem_addr); end
        tick();
        checks++; if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL full_rerun_done cpu_rst_n=%0b exp=1", cpu_rst_n); end
    endtask

    task automatic test_reset_mid();
        int c0;
        c0 = wr_count;
        pulse_start();
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 3; k++) send_word(32'hA5A50000 + 32'(k));
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'd0 || mem_wdata !== 32'd0) begin
            failures++; $display("FAIL mid_rst_port in_ready=%0b we=%0b addr=%0h data=%08h exp=0,0,0,0", in_ready, mem_we, mem_addr, mem_wdata); end
        checks++; if (cpu_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++; $display("FAIL mid_rst_status cpu_rst_n=%0b busy=%0b done=%0b err=%0b exp=0,0,0,0", cpu_rst_n, busy, done, err); end
        tick();
        checks++; if (wr_count - c0 !== 3 || mem_we !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL mid_writes writes=%0d we=%0b in_ready=%0b exp=3,0,0", wr_count - c0, mem_we, in_ready); end
        checks++; if (ram[0] !== 32'hA5A50000 || ram[2] !== 32'hA5A50002 || ram[3] !== 32'hC0DE0003) begin
            failures++; $display("FAIL mid_ram r0=%08h r2=%08h r3=%08h exp=a5a50000,a5a50002,c0de0003", ram[0], ram[2], ram[3]); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_too_long();
        test_full();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial program loader that fills the CPU's 32-bit instruction RAM from a byte stream and holds the CPU in reset until the image is complete. It is the write side of the instruction memory: the CPU fetch stage reads one word per cycle from the same RAM, and this block writes it. It sits between a byte source (UART receiver or test harness) and the RAM write port. It drives the CPU's active-low reset.

## Interface
- DEPTH, 4096: instruction RAM depth in 32-bit words.
- ADDR_W, 12: RAM word-address width; must satisfy 2^ADDR_W >= DEPTH.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERROR.
- in_valid  in  1  byte-source valid.
- in_data  in  8  byte payload.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid & in_ready at a rising edge.
- mem_we  out  1  RAM write strobe, one cycle per word.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- cpu_rst_n  out  1  active-low reset to the CPU; low while no valid image is loaded.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully; sticky until the next start or reset.
- err  out  1  last load rejected (length > DEPTH); sticky until the next start or reset.

## Operation
- Stream format: a 2-byte word count N, sent little-endian. N*4 data bytes follow. Each word is assembled little-endian: the first byte goes to [7:0], the fourth to [31:24]. Word k is written to address k.
- States: IDLE, LEN0, LEN1, DATA, FLUSH, DONE, ERROR.
- IDLE: in_ready=0, cpu_rst_n=0. start -> LEN0.
- LEN0: in_ready=1. On a byte transfer, latch N[7:0] -> LEN1.
- LEN1: in_ready=1. On a byte transfer, latch N[15:8]. Then:
  - N==0 -> DONE.
  - N>DEPTH -> ERROR.
  - Otherwise -> DATA with word index 0 and byte index 0.
- DATA: in_ready=1. Each transfer shifts the byte into the word assembler and increments the 2-bit byte index, which wraps 3->0.
  - On the 4th byte: register mem_wdata, set mem_addr to the word index, pulse mem_we for the following cycle, and increment the word index.
  - When the word index reaches N: -> FLUSH.
- FLUSH: in_ready=0. Waits one cycle for the last mem_we, then -> DONE.
- DONE: done=1, cpu_rst_n=1, in_ready=0. start -> LEN0.
- ERROR: err=1, cpu_rst_n=0, in_ready=0. start -> LEN0.
- busy=1 in LEN0, LEN1, DATA and FLUSH.
- Leaving DONE or ERROR on start clears done and err, and drives cpu_rst_n=0 from the next cycle.
- start is ignored while busy.
- The byte source may deassert in_valid at any time; the loader waits indefinitely.
- Bytes offered outside LEN0/LEN1/DATA are not accepted, because in_ready=0.
- RAM locations at addresses >= N are never written and keep their previous contents.

## Timing
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0. Byte, word and length registers are all 0.
- in_ready, busy, done, err and cpu_rst_n are decoded from the registered state only; there is no combinational path from in_valid.
- Let T be the edge on which the 4th byte of a word transfers. mem_we=1 for exactly the cycle after T, with stable mem_addr and mem_wdata.
  - Consecutive words can therefore produce mem_we every 4th cycle at full rate.
- Let T be the edge on which the last byte transfers. The final mem_we occurs in cycle T+1 and the block is in FLUSH during T+1. done=1 and cpu_rst_n=1 from cycle T+2, so the CPU never fetches before the last write.
- start in LEN1 through DATA has no effect.
- Reset mid-load: on the next edge all outputs return to their reset values. A pending mem_we is dropped. Words already written stay in RAM.
- The word counter is 16 bits, so N up to 65535 can be compared against DEPTH without overflow.

## Test plan
- Reset, then start, then bytes 02 00 | 13 05 50 00 | 73 10 00 00 at full rate: mem_we at addr 0 data 0x00500513, then at addr 1 data 0x00001073. done=1 and cpu_rst_n=1 two cycles after the last byte.
- Same image with in_valid toggled randomly: identical writes and final state; no byte is duplicated or lost.
- start then length 00 00: no mem_we; done=1 and cpu_rst_n=1 the cycle after the second length byte.
- Length 0x1001 (4097) with DEPTH=4096: err=1, cpu_rst_n=0, in_ready=0, and no mem_we; a new start then clears err.
- Full load with N=DEPTH: the last write goes to addr 4095 and the address does not wrap to 0. A second start then re-drives cpu_rst_n=0 until the new load completes.
- rst_n low for one cycle after the 2nd byte of word 3: all outputs return to reset values next cycle. Words 0-2 remain in RAM; no partial word 3 is written.
